// File: rtl/usb_fifo_dma_rd.sv
// usb_fifo_dma_rd: reads byte_count bytes from the usbHostSlave FIFO data port
// over the Avalon-MM master and packs them little-endian into 32-bit words on
// a valid/ready stream. One pack register (p0) feeds one output register (p1).
// Optional feature macro: USB_DMA_IRQ_EN (sticky completion interrupt).
module usb_fifo_dma_rd #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  fifo_addr,
  input  logic [7:0]  byte_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  avm_address,
  output logic        avm_read,
  output logic        avm_chipselect,
  input  logic [7:0]  avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        word_last,
  output logic [2:0]  word_bytes,
  input  logic        word_ready,
  output logic        irq,
  input  logic        irq_clr
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} stateT;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

  stateT       state;
  stateT       nextState;
  logic [7:0]  addrReg;
  logic [7:0]  remaining;
  logic [7:0]  waitCnt;
  logic        errReg;
  logic [31:0] packData_p0;
  logic [2:0]  packCnt_p0;
  logic [31:0] wordData_p1;
  logic [2:0]  wordBytes_p1;
  logic        wordLast_p1;
  logic        vld_p1;

  logic outFree;
  logic packFull;
  logic rdEn;
  logic byteDone;
  logic timeout;
  logic xfer;

  // Read is held off only while the pack register is full and cannot drain
  always_comb begin
    outFree  = !vld_p1 || word_ready;
    packFull = (packCnt_p0 == 3'd4);
    rdEn     = (state == READ) && (!packFull || outFree);
    byteDone = rdEn && !avm_waitrequest;
    timeout  = rdEn && avm_waitrequest && (waitCnt == WAIT_LIM);
    // remaining is nonzero throughout READ, so remaining == 0 marks the tail word
    xfer     = (packCnt_p0 != 3'd0) && (packFull || remaining == 8'd0) && outFree &&
               (state == READ || state == FLUSH);
  end

  // Next-state selection
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (start) nextState = (byte_count == 8'd0) ? DONE : READ;
      READ:  begin
        if (timeout) nextState = DONE;
        else if (byteDone && remaining == 8'd1) nextState = FLUSH;
      end
      FLUSH: if (packCnt_p0 == 3'd0 && vld_p1 && word_ready && wordLast_p1) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Transfer control: latched address, byte countdown, wait counter, error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrReg   <= 8'd0;
      remaining <= 8'd0;
      waitCnt   <= 8'd0;
      errReg    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addrReg   <= fifo_addr;
        remaining <= byte_count;
        errReg    <= 1'b0;
      end else if (byteDone) begin
        remaining <= remaining - 8'd1;
      end
      if (timeout) errReg <= 1'b1;
      waitCnt <= (rdEn && avm_waitrequest) ? waitCnt + 8'd1 : 8'd0;
    end
  end

  // Stage p0: pack incoming bytes little-endian; a full pack may drain and refill in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      packData_p0 <= 32'd0;
      packCnt_p0  <= 3'd0;
    end else if ((state == IDLE && start) || timeout) begin
      packData_p0 <= 32'd0;
      packCnt_p0  <= 3'd0;
    end else if (byteDone) begin
      if (xfer) begin
        packData_p0 <= {24'd0, avm_readdata};
        packCnt_p0  <= 3'd1;
      end else begin
        packData_p0[{packCnt_p0[1:0], 3'b000} +: 8] <= avm_readdata;
        packCnt_p0 <= packCnt_p0 + 3'd1;
      end
    end else if (xfer) begin
      packData_p0 <= 32'd0;
      packCnt_p0  <= 3'd0;
    end
  end

  // Stage p1: output word register, held while valid and not accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wordData_p1  <= 32'd0;
      wordBytes_p1 <= 3'd0;
      wordLast_p1  <= 1'b0;
      vld_p1       <= 1'b0;
    end else if (timeout) begin
      wordData_p1  <= 32'd0;
      wordBytes_p1 <= 3'd0;
      wordLast_p1  <= 1'b0;
      vld_p1       <= 1'b0;
    end else if (xfer) begin
      wordData_p1  <= packData_p0;
      wordBytes_p1 <= packCnt_p0;
      wordLast_p1  <= (remaining == 8'd0);
      vld_p1       <= 1'b1;
    end else if (vld_p1 && word_ready) begin
      wordLast_p1  <= 1'b0;
      vld_p1       <= 1'b0;
    end
  end

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign err            = errReg;
  assign avm_address    = addrReg;
  assign avm_read       = rdEn;
  assign avm_chipselect = rdEn;
  assign word_data      = wordData_p1;
  assign word_bytes     = wordBytes_p1;
  assign word_last      = wordLast_p1;
  assign word_valid     = vld_p1;

`ifdef USB_DMA_IRQ_EN
  logic irqReg;

  // Sticky interrupt: set wins over a coincident clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                irqReg <= 1'b0;
    else if (state == DONE)   irqReg <= 1'b1;
    else if (irq_clr)         irqReg <= 1'b0;
  end

  assign irq = irqReg;
`else
  logic unusedIrqClr;
  assign unusedIrqClr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: doc/usb_fifo_dma_rd.md
USB_FIFO_DMA_RD -- requirements
Module: usb_fifo_dma_rd

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, meaning the most consecutive waitrequest cycles tolerated per read (range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-005 SHALL have port fifo_addr  input  8  register address of the USB FIFO data port, sampled on start.
REQ-006 SHALL have port byte_count  input  8  bytes to read (1..255; 0 = empty transfer), sampled on start.
REQ-007 SHALL have port busy  output  1  transfer in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-009 SHALL have port err  output  1  last transfer aborted on timeout; held until next start.
REQ-010 SHALL have port avm_address / avm_read / avm_chipselect  output  8/1/1  master side of the usbHostSlave bus.
REQ-011 SHALL have port avm_readdata / avm_waitrequest  input  8/1  slave response.
REQ-012 SHALL have port word_data / word_valid / word_last / word_bytes  output  32/1/1/3  packed output stream.
REQ-013 SHALL have port word_ready  input  1  downstream accept.
REQ-014 SHALL have port irq / irq_clr  output / input  1 / 1  completion interrupt and clear.

Function
REQ-015 SHALL implement states IDLE, READ, FLUSH, DONE.
REQ-016 IDLE: start SHALL latch fifo_addr and byte_count, clear err, and enter READ (or DONE directly if byte_count = 0); start while busy SHALL be ignored.
REQ-017 READ: avm_read and avm_chipselect SHALL be high with avm_address = latched fifo_addr; a byte completes on a cycle with avm_read & ~avm_waitrequest, and avm_readdata is captured that cycle.
REQ-018 Bytes SHALL pack little-endian: the first byte of each word goes to word_data[7:0], the fourth to [31:24].
REQ-019 The pack register SHALL transfer to the output register on the clock after its 4th byte or after the final byte of the transfer; word_bytes = valid byte count (1..4); unused lanes = 0.
REQ-020 word_last SHALL be high with the output word carrying the final byte.
REQ-021 Output handshake: a word is consumed on a cycle with word_valid & word_ready; word_data, word_bytes, and word_last SHALL be stable while word_valid & ~word_ready.
REQ-022 When the pack register is full and the output register is still held, avm_read SHALL deassert until the output register frees (no byte loss, no duplicate read).
REQ-023 Remaining-byte counter SHALL decrement once per completed byte; on reaching 0, READ SHALL go to FLUSH.
REQ-024 FLUSH: SHALL wait until the last word is consumed, then enter DONE.
REQ-025 Timeout: if avm_waitrequest stays high for MAX_WAIT consecutive cycles of an asserted read, the block SHALL drop avm_read, discard pack and output registers, set err, and enter DONE.
REQ-026 DONE: done SHALL pulse for exactly one cycle, then the block SHALL return to IDLE; busy is high in READ, FLUSH, and DONE.
REQ-027 byte_count = 0 SHALL produce done with no bus reads, no words, and err = 0.

Reset
REQ-028 Reset SHALL force IDLE asynchronously; busy, done, err, avm_read, avm_chipselect, word_valid, word_last, and irq = 0; avm_address, word_data, and word_bytes = 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer without a done pulse.

Configuration
REQ-030 With USB_DMA_IRQ_EN defined, irq SHALL set on the done cycle and stay high until a cycle with irq_clr = 1; if done and irq_clr occur together, irq SHALL remain set.
REQ-031 Without USB_DMA_IRQ_EN, irq SHALL be constant 0, irq_clr SHALL be ignored, and both ports SHALL remain present.

Verification
REQ-032 byte_count = 8, no waitrequest, word_ready = 1 -> 8 reads at fifo_addr; words 0x04030201 and 0x08070605 (data 01..08); word_last set on the 2nd word; done pulse; err = 0.
REQ-033 byte_count = 5 -> second word has word_bytes = 1 and word_data = 0x00000005 with word_last = 1.
REQ-034 word_ready held low for 20 cycles during a 12-byte transfer -> reads stall after 8 bytes, output word stable, all 12 bytes delivered in order.
REQ-035 waitrequest stuck high, MAX_WAIT = 16 -> avm_read drops after 16 cycles, err = 1, done pulses, no word_valid.
REQ-036 Reset asserted mid-READ -> all outputs 0 immediately; no done pulse; next start runs normally.
REQ-037 USB_DMA_IRQ_EN build: done -> irq = 1 until irq_clr; done coincident with irq_clr -> irq stays 1.
